// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: value/update inputs and the scan outputs.
// The master drives the value updates; the slave is the scan controller.
interface seg_scan_ctrl_if;
  logic [15:0] VALUE;
  logic        LOAD;
  logic [3:0]  DP_IN;
  logic        LZB;
  logic [3:0]  D;
  logic [3:0]  AN;
  logic        DP_N;
  logic        FRAME;

  modport master (
    output VALUE, LOAD, DP_IN, LZB,
    input  D, AN, DP_N, FRAME
  );

  modport slave (
    input  VALUE, LOAD, DP_IN, LZB,
    output D, AN, DP_N, FRAME
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller feeding a 1-cycle registered 7-segment decoder.
// Each slot starts with a blanking gap that also covers the decoder latency.
//
//   state    | meaning
//   ST_BLANK | all anodes off, D already holds the slot's code
//   ST_SHOW  | anode of the current slot on, DP_N follows the shadow DP bit
module seg_scan_ctrl #(
  parameter int DIV          = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic         CLK,
  input  logic         RST,
  seg_scan_ctrl_if.slave bus
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYCLES);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [1:0]     slot;

  logic [15:0]    sh_val;
  logic [3:0]     sh_dp;
  logic           sh_lzb;
  logic [15:0]    pend_val;
  logic [3:0]     pend_dp;
  logic           pend_lzb;
  logic           pend_flag;

  logic [3:0]     d_q;
  logic [3:0]     an_q;
  logic           dp_n_q;
  logic           frame_q;

  logic           cnt_wrap;
  logic [CW-1:0]  cnt_nxt;
  logic [1:0]     slot_nxt;
  logic           boundary;
  logic [15:0]    sh_val_nxt;
  logic [3:0]     sh_dp_nxt;
  logic           sh_lzb_nxt;
  logic [3:0]     code_nxt;

  // Leading-zero blanking: digit k (k>0) blanks when it and all higher digits are zero.
  function automatic logic [3:0] disp_code(input logic [15:0] v, input logic lzb,
                                           input logic [1:0] k);
    logic lead;
    lead = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      if (j >= int'(k) && v[4*j +: 4] != 4'h0) lead = 1'b0;
    end
    if (lzb && k != 2'd0 && lead) return 4'hF;
    return v[4*k +: 4];
  endfunction

  always_comb begin
    cnt_wrap = (cnt == CNT_MAX);
    cnt_nxt  = cnt_wrap ? '0 : cnt + CW'(1);
    slot_nxt = cnt_wrap ? slot + 2'd1 : slot;
    boundary = cnt_wrap && (slot == 2'd3);
  end

  // Next shadow: a LOAD landing on the boundary edge bypasses the pending register.
  always_comb begin
    sh_val_nxt = sh_val;
    sh_dp_nxt  = sh_dp;
    sh_lzb_nxt = sh_lzb;
    if (boundary) begin
      if (bus.LOAD) begin
        sh_val_nxt = bus.VALUE;
        sh_dp_nxt  = bus.DP_IN;
        sh_lzb_nxt = bus.LZB;
      end else if (pend_flag) begin
        sh_val_nxt = pend_val;
        sh_dp_nxt  = pend_dp;
        sh_lzb_nxt = pend_lzb;
      end
    end
  end

  always_comb begin
    code_nxt = disp_code(sh_val_nxt, sh_lzb_nxt, slot_nxt);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_BLANK;
      cnt       <= CNT_MAX;
      slot      <= 2'd3;
      sh_val    <= '0;
      sh_dp     <= '0;
      sh_lzb    <= 1'b0;
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_lzb  <= 1'b0;
      pend_flag <= 1'b0;
      d_q       <= 4'hF;
      an_q      <= 4'hF;
      dp_n_q    <= 1'b1;
      frame_q   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      slot    <= slot_nxt;
      frame_q <= boundary;
      sh_val  <= sh_val_nxt;
      sh_dp   <= sh_dp_nxt;
      sh_lzb  <= sh_lzb_nxt;

      if (bus.LOAD && !boundary) begin
        pend_val  <= bus.VALUE;
        pend_dp   <= bus.DP_IN;
        pend_lzb  <= bus.LZB;
        pend_flag <= 1'b1;
      end else if (boundary) begin
        pend_flag <= 1'b0;
      end

      case (state)
        ST_BLANK: begin
          if (cnt_wrap) begin
            d_q    <= code_nxt;
            an_q   <= 4'hF;
            dp_n_q <= 1'b1;
          end else if (cnt_nxt == CNT_BLK) begin
            an_q   <= ~(4'b0001 << slot);
            dp_n_q <= ~sh_dp[slot];
            state  <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          // Anode drops on the same edge D changes; the decoder catches up during BLANK.
          if (cnt_wrap) begin
            d_q    <= code_nxt;
            an_q   <= 4'hF;
            dp_n_q <= 1'b1;
            state  <= ST_BLANK;
          end
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

  assign bus.D     = d_q;
  assign bus.AN    = an_q;
  assign bus.DP_N  = dp_n_q;
  assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and random checks for seg_scan_ctrl with DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;
  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FL  = 4 * DIV;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(.DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int pos   = FL - 1;

  task automatic tick();
    @(posedge CLK);
    #1;
    pos = (pos + 1) % FL;
  endtask

  // Expected {D, AN, DP_N, FRAME} at frame position p.
  function automatic logic [9:0] exp_vec(int p, logic [3:0] code, logic [3:0] dp);
    int c, s;
    logic [3:0] one, an;
    logic dpn;
    c = p % DIV;
    s = p / DIV;
    one = 4'b0001;
    if (c < BLK) begin
      an = 4'hF;
      dpn = 1'b1;
    end else begin
      an = ~(one << s);
      dpn = ~dp[s];
    end
    return {code, an, dpn, (p == 0)};
  endfunction

  function automatic logic [3:0] exp_code(logic [15:0] v, logic lzb, int k);
    logic [3:0] dig;
    dig = v[4*k +: 4];
    if (lzb) begin
      case (k)
        3: if (v[15:12] == 4'h0) dig = 4'hF;
        2: if (v[15:8]  == 8'h0) dig = 4'hF;
        1: if (v[15:4]  == 12'h0) dig = 4'hF;
        default: ;
      endcase
    end
    return dig;
  endfunction

  function automatic logic [9:0] got_vec();
    return {bus.D, bus.AN, bus.DP_N, bus.FRAME};
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    RST = 1'b1;
    #3;
    total++;
    if (got_vec() !== 10'b1111_1111_1_0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", got_vec(), 10'b1111_1111_1_0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    pos = FL - 1;
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, 4'h0, 4'h0);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL reset_frame pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
    end
  endtask

  task automatic test_load_midframe();
    logic [3:0] dig [4];
    logic [9:0] e;
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, 4'h0, 4'h0);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL load_old_frame pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
      if (pos == 10) begin
        bus.VALUE = 16'h1234; bus.DP_IN = 4'b0100; bus.LZB = 1'b0; bus.LOAD = 1'b1;
      end else begin
        bus.LOAD = 1'b0;
      end
    end
    dig = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, dig[pos / DIV], 4'b0100);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL load_new_frame pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
    end
  endtask

  task automatic test_lzb();
    logic [3:0] dig [4];
    logic [9:0] e;
    dig = '{4'h4, 4'h3, 4'h2, 4'h1};
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, dig[pos / DIV], 4'b0100);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL lzb_old_frame pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
      if (pos == 3) begin
        bus.VALUE = 16'h0050; bus.DP_IN = 4'b0000; bus.LZB = 1'b1; bus.LOAD = 1'b1;
      end else begin
        bus.LOAD = 1'b0;
      end
    end
    dig = '{4'h0, 4'h5, 4'hF, 4'hF};
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, dig[pos / DIV], 4'b0000);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL lzb_frame pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] dig [4];
    logic [9:0] e;
    dig = '{4'h0, 4'h5, 4'hF, 4'hF};
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, dig[pos / DIV], 4'b0000);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL b2b_old_frame pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
      bus.LOAD = 1'b0;
      if (pos == 5) begin
        bus.VALUE = 16'h1111; bus.DP_IN = 4'b0000; bus.LZB = 1'b0; bus.LOAD = 1'b1;
      end
      if (pos == 20) begin
        bus.VALUE = 16'h2222; bus.DP_IN = 4'b0000; bus.LZB = 1'b0; bus.LOAD = 1'b1;
      end
    end
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, 4'h2, 4'b0000);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL b2b_last_wins pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
    end
    bus.VALUE = 16'h3333; bus.DP_IN = 4'b0001; bus.LOAD = 1'b1;
    for (int i = 0; i < 2 * FL; i++) begin
      tick();
      bus.LOAD = 1'b0;
      e = exp_vec(pos, 4'h3, 4'b0001);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL b2b_boundary_bypass pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] e;
    while (pos != 20) tick();
    total++;
    if (bus.AN !== 4'b1011) begin
      bad++;
      $display("FAIL rst_mid_pre_an got=%b exp=%b", bus.AN, 4'b1011);
    end
    RST = 1'b1;
    #1;
    total++;
    if (got_vec() !== 10'b1111_1111_1_0) begin
      bad++;
      $display("FAIL rst_mid_immediate got=%b exp=%b", got_vec(), 10'b1111_1111_1_0);
    end
    @(negedge CLK);
    RST = 1'b0;
    pos = FL - 1;
    for (int i = 0; i < FL; i++) begin
      tick();
      e = exp_vec(pos, 4'h0, 4'h0);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL rst_mid_restart pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] m_val, p_val, in_val;
    logic [3:0]  m_dp, p_dp, in_dp, d_slot;
    logic        m_lzb, p_lzb, in_lzb, p_flag, ld;
    logic [9:0]  e;
    m_val = '0; m_dp = '0; m_lzb = 1'b0;
    p_val = '0; p_dp = '0; p_lzb = 1'b0; p_flag = 1'b0;
    d_slot = 4'h0;
    for (int i = 0; i < 1000 * FL; i++) begin
      ld = ($urandom_range(0, 15) == 0);
      in_val = 16'($urandom);
      if ($urandom_range(0, 1) == 1) in_val = in_val & 16'h00FF;
      in_dp  = 4'($urandom);
      in_lzb = 1'($urandom);
      bus.VALUE = in_val; bus.DP_IN = in_dp; bus.LZB = in_lzb; bus.LOAD = ld;
      tick();
      bus.LOAD = 1'b0;
      if (pos == 0) begin
        if (ld) begin
          m_val = in_val; m_dp = in_dp; m_lzb = in_lzb; p_flag = 1'b0;
        end else if (p_flag) begin
          m_val = p_val; m_dp = p_dp; m_lzb = p_lzb; p_flag = 1'b0;
        end
      end else if (ld) begin
        p_val = in_val; p_dp = in_dp; p_lzb = in_lzb; p_flag = 1'b1;
      end
      e = exp_vec(pos, exp_code(m_val, m_lzb, pos / DIV), m_dp);
      total++;
      if (got_vec() !== e) begin
        bad++;
        $display("FAIL rand_vec pos=%0d got=%b exp=%b", pos, got_vec(), e);
      end
      total++;
      if ($countones(~bus.AN) > 1 || ((pos % DIV) < BLK && bus.AN !== 4'hF)) begin
        bad++;
        $display("FAIL rand_anode pos=%0d got=%b exp=onehot0_blank", pos, bus.AN);
      end
      if ((pos % DIV) == 0) begin
        d_slot = bus.D;
      end else begin
        total++;
        if (bus.D !== d_slot) begin
          bad++;
          $display("FAIL rand_d_stable pos=%0d got=%h exp=%h", pos, bus.D, d_slot);
        end
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    bus.VALUE = '0;
    bus.LOAD  = 1'b0;
    bus.DP_IN = '0;
    bus.LZB   = 1'b0;
    test_reset();
    test_load_midframe();
    test_lzb();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
